mem_access_unit: RTL and testbench

Data-memory stage of the single-cycle MIPS datapath. It sits directly upstream of the memory-result capture register and produces the load word that register samples. It accepts one load or store request at a time from the ALU/control stage and holds a word-organised RAM with byte, halfword and word access. Loads are returned sign- or zero-extended after a configurable wait, and misaligned or out-of-range accesses are reported as errors.

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory stage: word-organised RAM with byte/half/word access, load extension,
// a programmable load wait and alignment/range error reporting.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   widx_q, widx_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    req_err;
  logic                    wr_en;
  logic [3:0]              be;
  logic [31:0]             wlane;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [1:0]              rd_off;
  logic [1:0]              rd_size;
  logic                    rd_uns;
  logic [31:0]             rd_word;
  logic [31:0]             load_val;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return w;
    endcase
  endfunction

  assign accept  = req_valid_i && (state_q == S_IDLE);
  assign req_idx = req_addr_i[ADDR_WIDTH+1:2];

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = |req_addr_i[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|req_addr_i[31:ADDR_WIDTH+2]) req_err = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    be    = 4'b0000;
    wlane = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be    = 4'b0001 << req_addr_i[1:0];
        wlane = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // A store landing on the same edge as reset must not reach the RAM.
  assign wr_en = accept && req_wr_i && !req_err && !rst_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[req_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // With no wait the load completes straight from IDLE, so read from the live request.
  always_comb begin
    rd_idx  = widx_q;
    rd_off  = off_q;
    rd_size = size_q;
    rd_uns  = uns_q;
    if (state_q == S_IDLE) begin
      rd_idx  = req_idx;
      rd_off  = req_addr_i[1:0];
      rd_size = req_size_i;
      rd_uns  = req_unsigned_i;
    end
  end

  assign rd_word  = mem[rd_idx];
  assign load_val = extend(rd_word, rd_size, rd_off, rd_uns);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      widx_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (req_wr_i) begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rdata_d = 32'd0;
          end else begin
            widx_d = req_idx;
            off_d  = req_addr_i[1:0];
            size_d = req_size_i;
            uns_d  = req_unsigned_i;
            if (WAIT_CYCLES == 0) begin
              state_d = S_RESP;
              err_d   = 1'b0;
              rdata_d = load_val;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    resp_valid_o = (state_q == S_RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table on a WAIT_CYCLES=1 instance,
// plus handshake and reset sequences, and a WAIT_CYCLES=0 instance for spacing.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v1 = 1'b0, v0 = 1'b0;
  logic        wr = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic        rdy1, rv1, er1, bz1;
  logic [31:0] rd1;
  logic        rdy0, rv0, er0, bz0;
  logic [31:0] rd0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_wr_i(wr), .req_size_i(sz),
    .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(wdata),
    .req_ready_o(rdy1), .resp_valid_o(rv1), .resp_rdata_o(rd1), .resp_err_o(er1),
    .busy_o(bz1)
  );

  mem_access_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_wr_i(wr), .req_size_i(sz),
    .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(wdata),
    .req_ready_o(rdy0), .resp_valid_o(rv0), .resp_rdata_o(rd0), .resp_err_o(er0),
    .busy_o(bz0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic cur_rdy(input bit sel); return sel ? rdy1 : rdy0; endfunction
  function automatic logic cur_rv(input bit sel);  return sel ? rv1 : rv0;   endfunction
  function automatic logic cur_er(input bit sel);  return sel ? er1 : er0;   endfunction
  function automatic logic cur_bz(input bit sel);  return sel ? bz1 : bz0;   endfunction
  function automatic logic [31:0] cur_rd(input bit sel); return sel ? rd1 : rd0; endfunction

  task automatic set_valid(input bit sel, input logic val);
    if (sel) v1 = val;
    else     v0 = val;
  endtask

  task automatic do_req(input bit sel, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic bz_first);
    int n;
    n = 0;
    @(negedge clk);
    while (!cur_rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    wr = w; sz = s; uns = u; addr = a; wdata = d;
    set_valid(sel, 1'b1);
    @(posedge clk);
    #1 set_valid(sel, 1'b0);
    lat = 0;
    bz_first = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bz_first = cur_bz(sel);
    end while (!cur_rv(sel) && lat < 40);
    rd = cur_rd(sel);
    e  = cur_er(sel);
    @(negedge clk);
    check("resp_one_cycle", 32'(cur_rv(sel)), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input string nm, input logic w, input logic [1:0] s,
                               input logic u, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] er, input logic ee, input int l);
    vec_t v;
    v.name = nm; v.wr = w; v.sz = s; v.uns = u; v.addr = a; v.wdata = d;
    v.exp_rd = er; v.exp_err = ee; v.exp_lat = l;
    vecs.push_back(v);
  endfunction

  // Response monitor used by the back-to-back handshake sequences.
  logic        mon_en = 1'b0;
  bit          mon_sel = 1'b1;
  int          mon_n = 0;
  logic [31:0] mon_data [8];

  always @(negedge clk) begin
    if (mon_en && cur_rv(mon_sel)) begin
      if (mon_n < 8) mon_data[mon_n] = cur_rd(mon_sel);
      mon_n++;
    end
  end

  logic [1:0]  hs_sz   [3];
  logic        hs_uns  [3];
  logic [31:0] hs_addr [3];
  logic [31:0] hs_exp  [3];

  task automatic handshake(input bit sel, input int spacing, input string tag);
    int acc [3];
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    mon_n = 0;
    mon_sel = sel;
    mon_en = 1'b1;
    @(negedge clk);
    wr = 1'b0; sz = hs_sz[0]; uns = hs_uns[0]; addr = hs_addr[0];
    set_valid(sel, 1'b1);
    while (k < 3 && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (cur_rdy(sel)) begin
        acc[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) begin
          sz = hs_sz[k]; uns = hs_uns[k]; addr = hs_addr[k];
        end else begin
          set_valid(sel, 1'b0);
        end
      end
    end
    set_valid(sel, 1'b0);
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    check({tag, "_accepts"}, 32'(k), 32'd3);
    if (k == 3) begin
      check({tag, "_spacing01"}, 32'(acc[1] - acc[0]), 32'(spacing));
      check({tag, "_spacing12"}, 32'(acc[2] - acc[1]), 32'(spacing));
    end
    check({tag, "_resp_count"}, 32'(mon_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < mon_n) check({tag, "_resp_data"}, mon_data[i], hs_exp[i]);
    end
  endtask

  logic [31:0] r_rd;
  logic        r_err;
  int          r_lat;
  logic        r_bz;

  initial begin
    addv("st_w_10",     1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 1);
    addv("ld_w_10",     0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2);
    addv("st_b_13",     1, 2'b00, 0, 32'h13,   32'h00000080, 32'h0,        0, 1);
    addv("ld_sb_13",    0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 2);
    addv("ld_ub_13",    0, 2'b00, 1, 32'h13,   32'h0,        32'h00000080, 0, 2);
    addv("ld_w_10b",    0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0, 2);
    addv("st_h_12",     1, 2'b01, 0, 32'h12,   32'h00001234, 32'h0,        0, 1);
    addv("ld_sh_12",    0, 2'b01, 0, 32'h12,   32'h0,        32'h00001234, 0, 2);
    addv("st_h_10",     1, 2'b01, 0, 32'h10,   32'h0000F00D, 32'h0,        0, 1);
    addv("ld_sh_10",    0, 2'b01, 0, 32'h10,   32'h0,        32'hFFFFF00D, 0, 2);
    addv("ld_uh_10",    0, 2'b01, 1, 32'h10,   32'h0,        32'h0000F00D, 0, 2);
    addv("err_ld_h_11", 0, 2'b01, 0, 32'h11,   32'h0,        32'h0,        1, 1);
    addv("st_w_14",     1, 2'b10, 0, 32'h14,   32'h11223344, 32'h0,        0, 1);
    addv("err_st_w_16", 1, 2'b10, 0, 32'h16,   32'hFFFFFFFF, 32'h0,        1, 1);
    addv("ld_w_14",     0, 2'b10, 0, 32'h14,   32'h0,        32'h11223344, 0, 2);
    addv("err_range",   0, 2'b10, 0, 32'h1000, 32'h0,        32'h0,        1, 1);
    addv("err_size11",  0, 2'b11, 0, 32'h20,   32'h0,        32'h0,        1, 1);
    addv("st_b_15",     1, 2'b00, 0, 32'h15,   32'h000000AB, 32'h0,        0, 1);
    addv("ld_sb_15",    0, 2'b00, 0, 32'h15,   32'h0,        32'hFFFFFFAB, 0, 2);
    addv("ld_uh_16",    0, 2'b01, 1, 32'h16,   32'h0,        32'h00001122, 0, 2);
    addv("st_b_14",     1, 2'b00, 0, 32'h14,   32'hFFFFFF5A, 32'h0,        0, 1);
    addv("ld_w_14b",    0, 2'b10, 0, 32'h14,   32'h0,        32'h1122AB5A, 0, 2);

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_busy",  32'(bz1),  32'd0);
    check("rst_rvalid", 32'(rv1), 32'd0);
    check("rst_err",   32'(er1),  32'd0);
    check("rst_rdata", rd1,       32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_req(1'b1, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             r_rd, r_err, r_lat, r_bz);
      check({vecs[i].name, "_rdata"}, r_rd, vecs[i].exp_rd);
      check({vecs[i].name, "_err"}, 32'(r_err), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_latency"}, 32'(r_lat), 32'(vecs[i].exp_lat));
      if (vecs[i].exp_lat > 1) check({vecs[i].name, "_busy_wait"}, 32'(r_bz), 32'd1);
    end

    // Reset while a load sits in WAIT.
    @(negedge clk);
    wr = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10; v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    check("rstw_busy", 32'(bz1), 32'd1);
    rst = 1'b1;
    #1 check("rstw_rvalid_async", 32'(rv1), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rstw_rvalid_hold", 32'(rv1), 32'd0);
    end
    rst = 1'b0;
    #1 check("rstw_ready", 32'(rdy1), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rstw_no_resp", 32'(rv1), 32'd0);
    end
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r_rd, r_err, r_lat, r_bz);
    check("rstw_load_rdata", r_rd, 32'h1122AB5A);
    check("rstw_load_latency", 32'(r_lat), 32'd2);

    hs_sz[0] = 2'b10; hs_uns[0] = 1'b0; hs_addr[0] = 32'h10; hs_exp[0] = 32'h1234F00D;
    hs_sz[1] = 2'b10; hs_uns[1] = 1'b0; hs_addr[1] = 32'h14; hs_exp[1] = 32'h1122AB5A;
    hs_sz[2] = 2'b01; hs_uns[2] = 1'b1; hs_addr[2] = 32'h12; hs_exp[2] = 32'h00001234;
    handshake(1'b1, 3, "hs_w1");

    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, r_rd, r_err, r_lat, r_bz);
    check("w0_store_latency", 32'(r_lat), 32'd1);
    check("w0_store_err", 32'(r_err), 32'd0);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, r_rd, r_err, r_lat, r_bz);
    check("w0_load_rdata", r_rd, 32'hCAFEF00D);
    check("w0_load_latency", 32'(r_lat), 32'd1);

    hs_sz[0] = 2'b10; hs_uns[0] = 1'b0; hs_addr[0] = 32'h40; hs_exp[0] = 32'hCAFEF00D;
    hs_sz[1] = 2'b01; hs_uns[1] = 1'b0; hs_addr[1] = 32'h42; hs_exp[1] = 32'hFFFFCAFE;
    hs_sz[2] = 2'b00; hs_uns[2] = 1'b1; hs_addr[2] = 32'h43; hs_exp[2] = 32'h000000CA;
    handshake(1'b0, 2, "hs_w0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
